// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel gradient-magnitude filter with internal border handling.
// One output per input pixel; window centre trails the newest pixel by IMG_WIDTH+1.
module sobel_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 720
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  border_mode,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = DATA_WIDTH + 3;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [2:0][2:0][DATA_WIDTH-1:0] win, nw, m;   // [row][col], row 0 = top
  logic out_valid, out_last, mode;
  logic slot_free, flush_adv, adv, load, out_end, border;
  logic top_ok, bot_ok, left_ok, right_ok;
  logic [DATA_WIDTH-1:0] pix, res;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0] ax, ay, mag;

  function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] x);
    return $signed({3'b000, x});
  endfunction

  assign slot_free  = !out_valid || out_wr_en;
  assign in_rd_en   = !in_empty && (state != FLUSH) && slot_free;
  assign flush_adv  = (state == FLUSH) && slot_free && !(out_valid && out_last);
  assign adv        = in_rd_en || flush_adv;
  assign load       = adv && (state != FILL);
  assign pix        = in_rd_en ? in_dout : '0;
  assign out_wr_en  = out_valid && !out_full;
  assign frame_done = out_wr_en && out_last;
  assign out_end    = (out_row == LAST_ROW) && (out_col == LAST_COL);

  // Neighbours outside the frame (including row-wrap columns) read as zero.
  assign top_ok   = out_row != '0;
  assign bot_ok   = out_row != LAST_ROW;
  assign left_ok  = out_col != '0;
  assign right_ok = out_col != LAST_COL;
  assign border   = !(top_ok && bot_ok && left_ok && right_ok);

  always_comb begin
    nw = '0;
    m  = '0;
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win[r][1];
      nw[r][1] = win[r][2];
    end
    nw[0][2] = lb1[in_col];
    nw[1][2] = lb0[in_col];
    nw[2][2] = pix;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if ((r != 0 || top_ok) && (r != 2 || bot_ok) && (c != 0 || left_ok) && (c != 2 || right_ok))
          m[r][c] = nw[r][c];
  end

  always_comb begin
    gx  = (ext(m[0][2]) + (ext(m[1][2]) <<< 1) + ext(m[2][2]))
        - (ext(m[0][0]) + (ext(m[1][0]) <<< 1) + ext(m[2][0]));
    gy  = (ext(m[2][0]) + (ext(m[2][1]) <<< 1) + ext(m[2][2]))
        - (ext(m[0][0]) + (ext(m[0][1]) <<< 1) + ext(m[0][2]));
    ax  = gx[GW-1] ? -gx : gx;
    ay  = gy[GW-1] ? -gy : gy;
    mag = ax + ay;
    res = (|mag[GW-1:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];
    if (mode && border) res = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (in_rd_en && in_row == RW'(1) && in_col == '0) state_nxt = RUN;
      RUN:   if (in_rd_en && in_row == LAST_ROW && in_col == LAST_COL) state_nxt = FLUSH;
      FLUSH: if (frame_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (adv) begin
      lb0[in_col] <= pix;
      lb1[in_col] <= lb0[in_col];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= FILL;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      win       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_din   <= '0;
      mode      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (frame_done) begin
        in_col  <= '0;
        in_row  <= '0;
        out_col <= '0;
        out_row <= '0;
      end else begin
        if (adv) begin
          win    <= nw;
          in_col <= (in_col == LAST_COL) ? '0 : in_col + 1'b1;
          if (in_col == LAST_COL) in_row <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
        end
        if (load) begin
          out_col <= (out_col == LAST_COL) ? '0 : out_col + 1'b1;
          if (out_col == LAST_COL) out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_din   <= res;
        out_last  <= out_end;
      end else if (out_wr_en) begin
        out_valid <= 1'b0;
      end
      if (in_rd_en && state == FILL && in_row == '0 && in_col == '0) mode <= border_mode;
      if (frame_done) busy <= 1'b0;
      else if (in_rd_en && state == FILL) busy <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// Randomised self-checking bench for sobel_stream on a 4x3 image against a
// kernel-sum reference model.
module tb_sobel_stream;
  localparam int DW = 8;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  typedef int frame_t [N];

  logic clock = 1'b0, reset = 1'b0, border_mode = 1'b0;
  logic in_rd_en, in_empty = 1'b1, out_wr_en, out_full = 1'b0, frame_done, busy;
  logic [DW-1:0] in_dout = '0, out_din;

  sobel_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .border_mode(border_mode),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .frame_done(frame_done), .busy(busy));

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  int src[$], got[$];
  int n_acc = 0, n_done = 0, first_wr_acc = -1;
  bit stall_in = 0, stall_out = 0, force_full = 0;
  frame_t fa, fb;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_out(input frame_t img, input bit mode, input int r, input int c);
    int gx, gy, v, rr, cc, s;
    gx = 0; gy = 0;
    if (mode && (r == 0 || r == H-1 || c == 0 || c == W-1)) return 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr; cc = c + dc;
        v = (rr < 0 || rr >= H || cc < 0 || cc >= W) ? 0 : img[rr*W + cc];
        gx += dc * ((dr == 0) ? 2 : 1) * v;
        gy += dr * ((dc == 0) ? 2 : 1) * v;
      end
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  // Drive the FIFO-side inputs at negedge, then record what the DUT will do
  // at the coming posedge.
  task automatic step();
    @(negedge clock);
    in_empty = (src.size() == 0) || (stall_in && ($urandom_range(0, 1) == 1));
    in_dout  = (src.size() != 0) ? DW'(src[0]) : '0;
    out_full = force_full || (stall_out && ($urandom_range(0, 1) == 1));
    #1;
    if (out_wr_en) begin
      if (got.size() == 0) first_wr_acc = n_acc;
      got.push_back(int'(out_din));
    end
    if (frame_done) begin
      n_done++;
      chk("done_with_write", int'(out_wr_en), 1);
      chk("done_at_frame_end", got.size() % N, 0);
    end
    if (in_rd_en) begin
      chk("rd_while_empty", int'(in_empty), 0);
      n_acc++;
      void'(src.pop_front());
    end
  endtask

  task automatic load(input frame_t img);
    for (int i = 0; i < N; i++) src.push_back(img[i]);
  endtask

  task automatic start();
    got.delete();
    n_acc = 0; n_done = 0; first_wr_acc = -1;
  endtask

  task automatic run_until(input int nout, input int stall_at);
    int cyc;
    bit stalled;
    int held;
    cyc = 0; stalled = 0; held = 0;
    while (got.size() < nout && cyc < 3000) begin
      if (stall_at >= 0 && got.size() == stall_at && !stalled) begin
        stalled = 1;
        force_full = 1;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("stall_no_wr", int'(out_wr_en), 0);
          if (s == 1) held = int'(out_din);
          if (s >= 1) chk("stall_no_rd", int'(in_rd_en), 0);
          if (s >= 2) chk("stall_hold", int'(out_din), held);
        end
        force_full = 0;
      end
      step();
      cyc++;
    end
    chk("out_count", got.size(), nout);
  endtask

  task automatic compare(input frame_t img, input bit mode, input int base, input string tag);
    for (int i = 0; i < N; i++)
      if (base + i < got.size()) chk(tag, got[base+i], ref_out(img, mode, i / W, i % W));
  endtask

  initial begin
    reset = 1'b0;
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr", int'(out_wr_en), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_dout", int'(out_din), 0);
    reset = 1'b1;
    step();

    // flat image, zero padding
    for (int i = 0; i < N; i++) fa[i] = 100;
    border_mode = 1'b0; start(); load(fa);
    run_until(N, -1);
    compare(fa, 0, 0, "flat_m0");
    chk("flat_corner", got[0], 255);
    chk("flat_interior", got[5], 0);
    chk("first_wr_acc", first_wr_acc, W + 2);
    chk("flat_done", n_done, 1);

    // flat image, forced-zero border
    border_mode = 1'b1; start(); load(fa);
    run_until(N, -1);
    compare(fa, 1, 0, "flat_m1");

    // horizontal ramp in both modes
    for (int i = 0; i < N; i++) fb[i] = 10 * (i % W);
    start(); load(fb);
    run_until(N, -1);
    compare(fb, 1, 0, "ramp_m1");
    chk("ramp_m1_int", got[W+1], 80);
    border_mode = 1'b0; start(); load(fb);
    run_until(N, -1);
    compare(fb, 0, 0, "ramp_m0");
    chk("ramp_m0_int", got[W+2], 80);

    // output held full for 5 cycles mid-run
    for (int i = 0; i < N; i++) fa[i] = $urandom_range(0, 255);
    start(); load(fa);
    run_until(N, 3);
    compare(fa, 0, 0, "stall");
    chk("stall_done", n_done, 1);

    // back-to-back frames under random handshake stalls
    stall_in = 1; stall_out = 1;
    for (int i = 0; i < N; i++) begin
      fa[i] = $urandom_range(0, 255);
      fb[i] = $urandom_range(0, 255);
    end
    start(); load(fa); load(fb);
    run_until(2 * N, -1);
    compare(fa, 0, 0, "rand_f0");
    compare(fb, 0, N, "rand_f1");
    chk("rand_done", n_done, 2);
    border_mode = 1'b1; start(); load(fb);
    run_until(N, -1);
    compare(fb, 1, 0, "rand_m1");
    stall_in = 0; stall_out = 0; border_mode = 1'b0;

    // reset after a partial frame, then a clean frame
    for (int i = 0; i < N; i++) fa[i] = $urandom_range(0, 255);
    start(); load(fa);
    for (int c = 0; c < 100 && n_acc < 7; c++) step();
    chk("partial_acc", n_acc, 7);
    src.delete();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_wr", int'(out_wr_en), 0);
    for (int i = 0; i < N; i++) fb[i] = $urandom_range(0, 255);
    start(); load(fb);
    run_until(N, -1);
    compare(fb, 0, 0, "after_rst");
    chk("after_rst_done", n_done, 1);
    for (int i = 0; i < 4; i++) step();
    chk("no_extra_out", got.size(), N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
